// File: rtl/stereo_window_feeder.sv
// Raster-to-window feeder for the stereo solver: line-buffers left/right pixel pairs and
// emits a MASK_SIZE-square left mask plus a MASK_SIZE x MATCH_WIDE right strip per pixel.
module stereo_window_feeder #(
    parameter int MASK_SIZE     = 3,
    parameter int MATCH_WIDE    = 16,
    parameter int IMG_WIDTH     = 640,
    parameter int IMG_HEIGHT    = 480,
    parameter int POSITION_BITS = 11
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  pix_valid,
    output logic                                  pix_ready,
    input  logic                                  pix_sof,
    input  logic [7:0]                            pix_left,
    input  logic [7:0]                            pix_right,
    output logic                                  win_valid,
    input  logic                                  win_ready,
    output logic [8*MASK_SIZE*MASK_SIZE-1:0]      flattern_mask,
    output logic [8*MASK_SIZE*MATCH_WIDE-1:0]     flattern_match_array,
    output logic [POSITION_BITS-1:0]              mask_position,
    output logic [POSITION_BITS-1:0]              match_position,
    output logic [POSITION_BITS-1:0]              win_row,
    output logic                                  frame_done
);

    localparam int LB_ROWS    = MASK_SIZE - 1;
    localparam int COL_AW     = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int MASK_BITS  = 8 * MASK_SIZE * MASK_SIZE;
    localparam int MATCH_BITS = 8 * MASK_SIZE * MATCH_WIDE;

    localparam logic [POSITION_BITS-1:0] LAST_COL  = POSITION_BITS'(IMG_WIDTH - 1);
    localparam logic [POSITION_BITS-1:0] LAST_ROW  = POSITION_BITS'(IMG_HEIGHT - 1);
    localparam logic [POSITION_BITS-1:0] MASK_OFS  = POSITION_BITS'(MASK_SIZE - 1);
    localparam logic [POSITION_BITS-1:0] STRIP_OFS = POSITION_BITS'(MATCH_WIDE - 1);
    localparam logic [POSITION_BITS-1:0] POS_ONE   = POSITION_BITS'(1);

    logic                       accept;
    logic                       emit;
    logic [POSITION_BITS-1:0]   row_cur;
    logic [POSITION_BITS-1:0]   col_cur;
    logic [COL_AW-1:0]          lb_addr;

    logic [POSITION_BITS-1:0]   row_q, row_d;
    logic [POSITION_BITS-1:0]   col_q, col_d;
    logic                       win_valid_q, win_valid_d;
    logic                       frame_done_q, frame_done_d;
    logic [MASK_BITS-1:0]       mask_q, mask_d;
    logic [MATCH_BITS-1:0]      match_q, match_d;
    logic [POSITION_BITS-1:0]   mask_pos_q, mask_pos_d;
    logic [POSITION_BITS-1:0]   match_pos_q, match_pos_d;
    logic [POSITION_BITS-1:0]   win_row_q, win_row_d;

    logic [7:0] rd_left  [LB_ROWS];
    logic [7:0] rd_right [LB_ROWS];
    logic [7:0] wr_left  [LB_ROWS];
    logic [7:0] wr_right [LB_ROWS];
    logic [7:0] cv_left  [MASK_SIZE];
    logic [7:0] cv_right [MASK_SIZE];

    logic [7:0] lwin_q [MASK_SIZE][MASK_SIZE];
    logic [7:0] lwin_d [MASK_SIZE][MASK_SIZE];
    logic [7:0] rwin_q [MASK_SIZE][MATCH_WIDE];
    logic [7:0] rwin_d [MASK_SIZE][MATCH_WIDE];

    // Single output register, no skid: input stalls whenever a window is held unconsumed.
    assign pix_ready = !rst && (!win_valid_q || win_ready);
    assign accept    = pix_valid && pix_ready;
    assign row_cur   = pix_sof ? '0 : row_q;
    assign col_cur   = pix_sof ? '0 : col_q;
    assign lb_addr   = col_cur[COL_AW-1:0];
    assign emit      = (row_cur >= MASK_OFS) && (col_cur >= STRIP_OFS);

    for (genvar k = 0; k < LB_ROWS; k++) begin : g_lb
        logic [7:0] mem_left  [IMG_WIDTH];
        logic [7:0] mem_right [IMG_WIDTH];

        assign rd_left[k]  = mem_left[lb_addr];
        assign rd_right[k] = mem_right[lb_addr];

        always_ff @(posedge clk) begin
            if (accept) begin
                mem_left[lb_addr]  <= wr_left[k];
                mem_right[lb_addr] <= wr_right[k];
            end
        end
    end

    // Each buffer row ages by one line per write; row 0 of the column vector is the oldest line.
    always_comb begin
        for (int k = 0; k < LB_ROWS; k++) begin
            wr_left[k]  = (k == 0) ? pix_left  : rd_left[(k == 0) ? 0 : k - 1];
            wr_right[k] = (k == 0) ? pix_right : rd_right[(k == 0) ? 0 : k - 1];
        end
        for (int j = 0; j < LB_ROWS; j++) begin
            cv_left[j]  = rd_left[LB_ROWS-1-j];
            cv_right[j] = rd_right[LB_ROWS-1-j];
        end
        cv_left[MASK_SIZE-1]  = pix_left;
        cv_right[MASK_SIZE-1] = pix_right;
    end

    always_comb begin
        lwin_d = lwin_q;
        rwin_d = rwin_q;
        if (accept) begin
            for (int j = 0; j < MASK_SIZE; j++) begin
                for (int k = 0; k < MASK_SIZE - 1; k++) begin
                    lwin_d[j][k] = lwin_q[j][k+1];
                end
                lwin_d[j][MASK_SIZE-1] = cv_left[j];
                for (int k = 0; k < MATCH_WIDE - 1; k++) begin
                    rwin_d[j][k] = rwin_q[j][k+1];
                end
                rwin_d[j][MATCH_WIDE-1] = cv_right[j];
            end
        end
    end

    always_comb begin
        row_d        = row_q;
        col_d        = col_q;
        win_valid_d  = win_valid_q;
        frame_done_d = 1'b0;
        mask_d       = mask_q;
        match_d      = match_q;
        mask_pos_d   = mask_pos_q;
        match_pos_d  = match_pos_q;
        win_row_d    = win_row_q;

        if (win_ready) begin
            win_valid_d = 1'b0;
        end

        if (accept) begin
            if (col_cur == LAST_COL) begin
                col_d = '0;
                if (row_cur == LAST_ROW) begin
                    row_d        = '0;
                    frame_done_d = 1'b1;
                end else begin
                    row_d = row_cur + POS_ONE;
                end
            end else begin
                col_d = col_cur + POS_ONE;
                row_d = row_cur;
            end

            // Row/column gating keeps stale previous-line or previous-frame data out of windows.
            if (emit) begin
                win_valid_d = 1'b1;
                mask_pos_d  = col_cur - MASK_OFS;
                match_pos_d = col_cur - STRIP_OFS;
                win_row_d   = row_cur - MASK_OFS;
                for (int j = 0; j < MASK_SIZE; j++) begin
                    for (int k = 0; k < MASK_SIZE; k++) begin
                        mask_d[(j*MASK_SIZE+k)*8 +: 8] = lwin_d[j][k];
                    end
                    for (int k = 0; k < MATCH_WIDE; k++) begin
                        match_d[(j*MATCH_WIDE+k)*8 +: 8] = rwin_d[j][k];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q        <= '0;
            col_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            mask_q       <= '0;
            match_q      <= '0;
            mask_pos_q   <= '0;
            match_pos_q  <= '0;
            win_row_q    <= '0;
        end else begin
            row_q        <= row_d;
            col_q        <= col_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
            mask_q       <= mask_d;
            match_q      <= match_d;
            mask_pos_q   <= mask_pos_d;
            match_pos_q  <= match_pos_d;
            win_row_q    <= win_row_d;
        end
    end

    // Shift windows need no reset: their contents only reach the outputs through emit gating.
    always_ff @(posedge clk) begin
        lwin_q <= lwin_d;
        rwin_q <= rwin_d;
    end

    assign win_valid            = win_valid_q;
    assign frame_done           = frame_done_q;
    assign flattern_mask        = mask_q;
    assign flattern_match_array = match_q;
    assign mask_position        = mask_pos_q;
    assign match_position       = match_pos_q;
    assign win_row              = win_row_q;

endmodule

// File: tb/tb_stereo_window_feeder.sv
// Scoreboard bench for stereo_window_feeder: a frame-image reference model predicts every window,
// a separate monitor checks each handshake, stall freezes and frame_done timing.
module tb_stereo_window_feeder;

    localparam int MS  = 3;
    localparam int MW  = 16;
    localparam int W   = 32;
    localparam int H   = 8;
    localparam int PB  = 11;
    localparam int WPF = (W - MW + 1) * (H - MS + 1);

    logic clk, rst;
    logic pix_valid, pix_ready, pix_sof;
    logic [7:0] pix_left, pix_right;
    logic win_valid, win_ready, frame_done;
    logic [8*MS*MS-1:0] flattern_mask;
    logic [8*MS*MW-1:0] flattern_match_array;
    logic [PB-1:0] mask_position, match_position, win_row;

    stereo_window_feeder #(
        .MASK_SIZE(MS), .MATCH_WIDE(MW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .POSITION_BITS(PB)
    ) dut (
        .clk(clk), .rst(rst),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_sof(pix_sof),
        .pix_left(pix_left), .pix_right(pix_right),
        .win_valid(win_valid), .win_ready(win_ready),
        .flattern_mask(flattern_mask), .flattern_match_array(flattern_match_array),
        .mask_position(mask_position), .match_position(match_position),
        .win_row(win_row), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct packed {
        logic [8*MS*MS-1:0] mask;
        logic [8*MS*MW-1:0] strip;
        logic [PB-1:0]      mp;
        logic [PB-1:0]      sp;
        logic [PB-1:0]      row;
    } win_t;

    win_t exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [383:0] act, input logic [383:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: whole-frame image arrays indexed by raster position.
    int img_l[H][W];
    int img_r[H][W];
    int mr = 0, mc = 0;
    int fd_cycle = -100;

    task automatic model_accept(input bit sof, input int l, input int r);
        win_t e;
        if (sof) begin mr = 0; mc = 0; end
        img_l[mr][mc] = l;
        img_r[mr][mc] = r;
        if (mr >= MS - 1 && mc >= MW - 1) begin
            for (int j = 0; j < MS; j++) begin
                for (int k = 0; k < MS; k++)
                    e.mask[(j*MS+k)*8 +: 8] = 8'(img_l[mr-MS+1+j][mc-MS+1+k]);
                for (int k = 0; k < MW; k++)
                    e.strip[(j*MW+k)*8 +: 8] = 8'(img_r[mr-MS+1+j][mc-MW+1+k]);
            end
            e.mp  = PB'(mc - MS + 1);
            e.sp  = PB'(mc - MW + 1);
            e.row = PB'(mr - MS + 1);
            exp_q.push_back(e);
        end
        if (mc == W - 1) begin
            mc = 0;
            if (mr == H - 1) begin mr = 0; fd_cycle = cyc + 1; end
            else mr++;
        end else begin
            mc++;
        end
    endtask

    // Monitor
    int win_cnt = 0, fd_cnt = 0, stall_cnt = 0;
    bit hold = 0, disp_mode = 0, first_seen = 0;
    logic [8*MS*MS-1:0] saved_mask, first_mask;
    logic [8*MS*MW-1:0] saved_strip, first_strip;
    logic [3*PB-1:0]    saved_pos, first_pos;
    win_t mon_e;

    always @(negedge clk) begin
        if (!rst) begin
            check("frame_done", frame_done, cyc == fd_cycle);
            if (frame_done) fd_cnt++;
            if (!win_valid) check("pix_ready_idle", pix_ready, 1'b1);
            if (hold) begin
                check("stall_valid", win_valid, 1'b1);
                check("stall_mask", flattern_mask, saved_mask);
                check("stall_strip", flattern_match_array, saved_strip);
                check("stall_pos", {mask_position, match_position, win_row}, saved_pos);
            end
            if (win_valid && !win_ready) begin
                stall_cnt++;
                check("stall_pix_ready", pix_ready, 1'b0);
                saved_mask  = flattern_mask;
                saved_strip = flattern_match_array;
                saved_pos   = {mask_position, match_position, win_row};
                hold = 1;
            end else begin
                hold = 0;
            end
            if (win_valid && win_ready) begin
                win_cnt++;
                if (!first_seen) begin
                    first_seen  = 1;
                    first_mask  = flattern_mask;
                    first_strip = flattern_match_array;
                    first_pos   = {mask_position, match_position, win_row};
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_window: got window at col %0d row %0d, required none",
                             mask_position, win_row);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("win_mask", flattern_mask, mon_e.mask);
                    check("win_strip", flattern_match_array, mon_e.strip);
                    check("mask_position", mask_position, mon_e.mp);
                    check("match_position", match_position, mon_e.sp);
                    check("win_row", win_row, mon_e.row);
                end
                if (disp_mode) begin
                    logic [71:0] a, b;
                    for (int j = 0; j < MS; j++)
                        for (int k = 0; k < MS; k++) begin
                            a[(j*MS+k)*8 +: 8] = flattern_match_array[(j*MW+9+k)*8 +: 8];
                            b[(j*MS+k)*8 +: 8] = flattern_mask[(j*MS+k)*8 +: 8];
                        end
                    check("disparity4", a, b);
                end
            end
        end
    end

    // Consumer: 0 = always ready, 1 = random, 2 = one 5-cycle stall on the next window.
    int ready_mode = 0;
    initial begin
        forever begin
            @(posedge clk); #1;
            if (ready_mode == 1) begin
                win_ready = ($urandom_range(0, 3) != 0);
            end else if (ready_mode == 2 && win_valid) begin
                win_ready = 1'b0;
                repeat (5) begin @(posedge clk); #1; end
                win_ready  = 1'b1;
                ready_mode = 0;
            end else begin
                win_ready = 1'b1;
            end
        end
    end

    // Stimulus
    bit gap_en = 0;
    int gl[H][W];
    int gr[H][W];

    task automatic send_pixel(input bit sof, input int l, input int r);
        int gaps, guard;
        bit done;
        gaps = gap_en ? int'($urandom_range(0, 2)) : 0;
        repeat (gaps) begin
            pix_valid = 1'b0;
            pix_sof   = 1'($urandom_range(0, 1));
            pix_left  = 8'($urandom);
            pix_right = 8'($urandom);
            @(posedge clk); #1;
        end
        pix_valid = 1'b1;
        pix_sof   = sof;
        pix_left  = 8'(l);
        pix_right = 8'(r);
        guard = 0;
        done  = 0;
        while (!done) begin
            @(negedge clk);
            if (pix_ready) begin
                model_accept(sof, l, r);
                done = 1;
            end
            @(posedge clk); #1;
            if (!done) begin
                guard++;
                if (guard > 100) begin
                    checks++;
                    errors++;
                    $display("FAIL accept_timeout: pix_ready low for %0d cycles, required accept", guard);
                    done = 1;
                end
            end
        end
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic gen_frame(input int mode);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                gl[r][c] = (mode == 0) ? r * W + c : int'($urandom_range(0, 255));
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                if (mode == 0) gr[r][c] = gl[r][c];
                else if (mode == 1 && c + 4 < W) gr[r][c] = gl[r][c+4];
                else gr[r][c] = int'($urandom_range(0, 255));
    endtask

    task automatic send_frame(input int stop_idx);
        for (int i = 0; i < stop_idx; i++)
            send_pixel(i == 0, gl[i/W][i%W], gr[i/W][i%W]);
    endtask

    int ph_win, ph_fd;
    task automatic start_phase();
        ph_win = win_cnt;
        ph_fd  = fd_cnt;
    endtask

    task automatic end_phase(input string name, input int exp_w, input int exp_fd);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || win_valid) && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        check({name, "_drain"}, exp_q.size(), 0);
        check({name, "_windows"}, win_cnt - ph_win, exp_w);
        check({name, "_frame_done"}, fd_cnt - ph_fd, exp_fd);
    endtask

    initial begin
        logic [127:0] ramp_row0;
        int s0;
        rst = 1'b1; pix_valid = 1'b1; pix_sof = 1'b0;
        pix_left = 8'hAA; pix_right = 8'h55; win_ready = 1'b1;

        repeat (3) begin
            @(posedge clk); #1;
            check("rst_pix_ready", pix_ready, 1'b0);
            check("rst_win_valid", win_valid, 1'b0);
            check("rst_mask", flattern_mask, 0);
            check("rst_strip", flattern_match_array, 0);
            check("rst_pos", {mask_position, match_position, win_row, frame_done}, 0);
        end
        rst = 1'b0;
        pix_valid = 1'b0;
        #1;
        check("pix_ready_after_rst", pix_ready, 1'b1);

        // Ramp frame, fixed first-window expectations
        start_phase();
        gen_frame(0);
        send_frame(W * H);
        end_phase("ramp", WPF, 1);
        for (int k = 0; k < 16; k++) ramp_row0[k*8 +: 8] = 8'(k);
        check("first_positions", first_pos, {11'd13, 11'd0, 11'd0});
        check("first_mask_row0", first_mask[23:0], {8'd15, 8'd14, 8'd13});
        check("first_mask_row2", first_mask[71:48], {8'd79, 8'd78, 8'd77});
        check("first_strip_row0", first_strip[127:0], ramp_row0);

        // Disparity-4 frames with random gaps and random consumer
        ready_mode = 1; gap_en = 1; disp_mode = 1;
        start_phase();
        repeat (2) begin gen_frame(1); send_frame(W * H); end
        end_phase("disparity", 2 * WPF, 2);
        disp_mode = 0;

        // Five-cycle consumer stall
        ready_mode = 2;
        s0 = stall_cnt;
        start_phase();
        gen_frame(2);
        send_frame(W * H);
        end_phase("stall", WPF, 1);
        check("stall_cycles", stall_cnt - s0, 5);

        // Mid-frame sof at (4,10), then a full frame
        ready_mode = 0;
        start_phase();
        gen_frame(0);
        send_frame(4 * W + 10);
        gen_frame(0);
        send_frame(W * H);
        end_phase("sof_abort", 2 * (W - MW + 1) + WPF, 1);

        // Back-to-back frames, continuous valid
        gap_en = 0;
        start_phase();
        gen_frame(2); send_frame(W * H);
        gen_frame(2); send_frame(W * H);
        end_phase("back_to_back", 2 * WPF, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
